sc_regpoint_autoshift: RTL and testbench

Parametrised point-type register: clear, parallel load and timed automatic shifting.
- Modes: hold, rotate left, rotate right, bounce (ping-pong between edges).
- A prescaler paces the steps; a step counter ends a run with a done pulse.
- Drives a moving-point pattern for display/LED paths; the control FSM issues start, mode and step count.

---
 rtl/sc_regpoint_autoshift_if.sv | 58 +++++
 rtl/sc_regpoint_autoshift.sv | 137 +++++++++++++
 tb/tb_sc_regpoint_autoshift.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sc_regpoint_autoshift_if.sv
// Control/data bundle for the auto-shifting point register.
// Edge flag signal exists only with SC_REGPOINT_EDGEFLAG_EN defined.
interface sc_regpoint_autoshift_if #(
   parameter int DATAWIDTH  = 8,
   parameter int STEP_WIDTH = 8
);
   logic                  SC_RegPOINTTYPE_clear_InLow;
   logic                  SC_RegPOINTTYPE_load_InLow;
   logic [DATAWIDTH-1:0]  SC_RegPOINTTYPE_data_InBUS;
   logic [1:0]            SC_RegPOINTTYPE_mode_In;
   logic                  SC_RegPOINTTYPE_enable_In;
   logic                  SC_RegPOINTTYPE_start_In;
   logic [STEP_WIDTH-1:0] SC_RegPOINTTYPE_steps_In;
   logic [DATAWIDTH-1:0]  SC_RegPOINTTYPE_data_OutBUS;
   logic                  SC_RegPOINTTYPE_dir_Out;
   logic                  SC_RegPOINTTYPE_busy_Out;
   logic                  SC_RegPOINTTYPE_tick_Out;
   logic                  SC_RegPOINTTYPE_done_Out;
`ifdef SC_REGPOINT_EDGEFLAG_EN
   logic                  SC_RegPOINTTYPE_edge_Out;
`endif

   modport master (
      output SC_RegPOINTTYPE_clear_InLow,
      output SC_RegPOINTTYPE_load_InLow,
      output SC_RegPOINTTYPE_data_InBUS,
      output SC_RegPOINTTYPE_mode_In,
      output SC_RegPOINTTYPE_enable_In,
      output SC_RegPOINTTYPE_start_In,
      output SC_RegPOINTTYPE_steps_In,
      input  SC_RegPOINTTYPE_data_OutBUS,
      input  SC_RegPOINTTYPE_dir_Out,
      input  SC_RegPOINTTYPE_busy_Out,
      input  SC_RegPOINTTYPE_tick_Out,
`ifdef SC_REGPOINT_EDGEFLAG_EN
      input  SC_RegPOINTTYPE_edge_Out,
`endif
      input  SC_RegPOINTTYPE_done_Out
   );

   modport slave (
      input  SC_RegPOINTTYPE_clear_InLow,
      input  SC_RegPOINTTYPE_load_InLow,
      input  SC_RegPOINTTYPE_data_InBUS,
      input  SC_RegPOINTTYPE_mode_In,
      input  SC_RegPOINTTYPE_enable_In,
      input  SC_RegPOINTTYPE_start_In,
      input  SC_RegPOINTTYPE_steps_In,
      output SC_RegPOINTTYPE_data_OutBUS,
      output SC_RegPOINTTYPE_dir_Out,
      output SC_RegPOINTTYPE_busy_Out,
      output SC_RegPOINTTYPE_tick_Out,
`ifdef SC_REGPOINT_EDGEFLAG_EN
      output SC_RegPOINTTYPE_edge_Out,
`endif
      output SC_RegPOINTTYPE_done_Out
   );
endinterface

// File: rtl/sc_regpoint_autoshift.sv
// Point register with clear/load and prescaled rotate/bounce runs.
// Optional SC_REGPOINT_EDGEFLAG_EN adds a bounce-reversal pulse output.
module sc_regpoint_autoshift #(
   parameter int DATAWIDTH  = 8,
   parameter logic [DATAWIDTH-1:0] INIT_VALUE = {{(DATAWIDTH-1){1'b0}}, 1'b1},
   parameter int TICK_DIV   = 4,
   parameter int STEP_WIDTH = 8
) (
   input logic SC_RegPOINTTYPE_CLOCK_50,
   input logic SC_RegPOINTTYPE_RESET_InHigh,
   sc_regpoint_autoshift_if.slave bus
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state_q, state_d;
   logic [DATAWIDTH-1:0]  data_q, data_d;
   logic                  dir_q, dir_d;
   logic [PW-1:0]         presc_q, presc_d;
   logic [STEP_WIDTH-1:0] rem_q, rem_d;

   logic [DATAWIDTH-1:0]  rol, ror, step_data;
   logic                  step_dir, rev, tick;

   assign rol  = {data_q[DATAWIDTH-2:0], data_q[DATAWIDTH-1]};
   assign ror  = {data_q[0], data_q[DATAWIDTH-1:1]};
   assign tick = (state_q == RUN) && bus.SC_RegPOINTTYPE_enable_In
              && (presc_q == PMAX);
   assign rev  = (bus.SC_RegPOINTTYPE_mode_In == 2'b11)
              && (dir_q ? data_q[0] : data_q[DATAWIDTH-1]);

   always_comb begin
      step_data = data_q;
      step_dir  = dir_q;
      unique case (bus.SC_RegPOINTTYPE_mode_In)
         2'b00: begin
            step_data = data_q;
            step_dir  = dir_q;
         end
         2'b01: begin
            step_data = rol;
            step_dir  = 1'b0;
         end
         2'b10: begin
            step_data = ror;
            step_dir  = 1'b1;
         end
         2'b11: begin
            // Bounce: flip direction when the point sits on the leading edge
            step_dir  = rev ? ~dir_q : dir_q;
            step_data = step_dir ? ror : rol;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      dir_d   = dir_q;
      presc_d = presc_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE: begin
            if (bus.SC_RegPOINTTYPE_start_In) begin
               state_d = RUN;
               rem_d   = bus.SC_RegPOINTTYPE_steps_In;
               presc_d = '0;
            end
         end
         RUN: begin
            if (tick) begin
               presc_d = '0;
               data_d  = step_data;
               dir_d   = step_dir;
               // rem_q==0 in RUN means free run
               if (rem_q != '0) begin
                  rem_d = rem_q - STEP_WIDTH'(1);
                  if (rem_q == STEP_WIDTH'(1)) state_d = DONE;
               end
            end else if (bus.SC_RegPOINTTYPE_enable_In) begin
               presc_d = presc_q + PW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (!bus.SC_RegPOINTTYPE_load_InLow) begin
         data_d = bus.SC_RegPOINTTYPE_data_InBUS;
         dir_d  = dir_q;
      end
      if (!bus.SC_RegPOINTTYPE_clear_InLow) begin
         state_d = IDLE;
         data_d  = INIT_VALUE;
         dir_d   = 1'b0;
         presc_d = '0;
         rem_d   = '0;
      end
   end

   always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
      if (SC_RegPOINTTYPE_RESET_InHigh) begin
         state_q <= IDLE;
         data_q  <= '0;
         dir_q   <= 1'b0;
         presc_q <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         dir_q   <= dir_d;
         presc_q <= presc_d;
         rem_q   <= rem_d;
      end
   end

`ifdef SC_REGPOINT_EDGEFLAG_EN
   logic edge_q, edge_d;

   assign edge_d = tick && rev && bus.SC_RegPOINTTYPE_load_InLow
                && bus.SC_RegPOINTTYPE_clear_InLow;

   always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
      if (SC_RegPOINTTYPE_RESET_InHigh) edge_q <= 1'b0;
      else                              edge_q <= edge_d;
   end

   assign bus.SC_RegPOINTTYPE_edge_Out = edge_q;
`endif

   assign bus.SC_RegPOINTTYPE_data_OutBUS = data_q;
   assign bus.SC_RegPOINTTYPE_dir_Out     = dir_q;
   assign bus.SC_RegPOINTTYPE_busy_Out    = (state_q == RUN);
   assign bus.SC_RegPOINTTYPE_done_Out    = (state_q == DONE);
   assign bus.SC_RegPOINTTYPE_tick_Out    = tick;
endmodule

// File: tb/tb_sc_regpoint_autoshift.sv
// Directed vector bench for sc_regpoint_autoshift (TICK_DIV=4, 8 bits).
// Table-driven runs plus hand sequences for free run, load, clear, reset.
module tb_sc_regpoint_autoshift;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   sc_regpoint_autoshift_if #(.DATAWIDTH(8), .STEP_WIDTH(8)) bus ();

   sc_regpoint_autoshift #(
      .DATAWIDTH(8), .INIT_VALUE(8'h01), .TICK_DIV(4), .STEP_WIDTH(8)
   ) dut (
      .SC_RegPOINTTYPE_CLOCK_50(clk),
      .SC_RegPOINTTYPE_RESET_InHigh(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       clr_n;
      logic       ld_n;
      logic [7:0] din;
      logic [1:0] mode;
      logic       en;
      logic       start;
      logic [7:0] steps;
      int         ncyc;
      logic [7:0] e_data;
      logic       e_dir;
      logic       e_busy;
      logic       e_done;
   } vec_t;

   vec_t tbl[$];

`ifdef SC_REGPOINT_EDGEFLAG_EN
   int edges = 0;
   always @(posedge clk) if (bus.SC_RegPOINTTYPE_edge_Out) edges++;
`endif

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic clr_n, input logic ld_n,
                        input logic [7:0] din, input logic [1:0] mode,
                        input logic en, input logic start,
                        input logic [7:0] steps);
      bus.SC_RegPOINTTYPE_clear_InLow = clr_n;
      bus.SC_RegPOINTTYPE_load_InLow  = ld_n;
      bus.SC_RegPOINTTYPE_data_InBUS  = din;
      bus.SC_RegPOINTTYPE_mode_In     = mode;
      bus.SC_RegPOINTTYPE_enable_In   = en;
      bus.SC_RegPOINTTYPE_start_In    = start;
      bus.SC_RegPOINTTYPE_steps_In    = steps;
   endtask

   task automatic chk4(input string tag, input logic [7:0] d, input logic dr,
                       input logic b, input logic dn);
      chk({tag, ".data"}, 32'(bus.SC_RegPOINTTYPE_data_OutBUS), 32'(d));
      chk({tag, ".dir"},  32'(bus.SC_RegPOINTTYPE_dir_Out), 32'(dr));
      chk({tag, ".busy"}, 32'(bus.SC_RegPOINTTYPE_busy_Out), 32'(b));
      chk({tag, ".done"}, 32'(bus.SC_RegPOINTTYPE_done_Out), 32'(dn));
   endtask

   function automatic vec_t v(logic clr_n, logic ld_n, logic [7:0] din,
                              logic [1:0] mode, logic en, logic start,
                              logic [7:0] steps, int ncyc, logic [7:0] ed,
                              logic edr, logic eb, logic edn);
      vec_t r;
      r.clr_n = clr_n; r.ld_n = ld_n; r.din = din; r.mode = mode;
      r.en = en; r.start = start; r.steps = steps; r.ncyc = ncyc;
      r.e_data = ed; r.e_dir = edr; r.e_busy = eb; r.e_done = edn;
      return r;
   endfunction

   initial begin
      logic [7:0] bdat [9];
      logic       bdir [9];
      bdat = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
      bdir = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      // clear, then rotate-left run of 3 steps
      tbl.push_back(v(0, 1, 8'h00, 2'b01, 1, 0, 8'd0, 1, 8'h01, 0, 0, 0));
      tbl.push_back(v(1, 1, 8'h00, 2'b01, 1, 1, 8'd3, 1, 8'h01, 0, 1, 0));
      tbl.push_back(v(1, 1, 8'h00, 2'b01, 1, 0, 8'd0, 3, 8'h01, 0, 1, 0));
      tbl.push_back(v(1, 1, 8'h00, 2'b01, 1, 0, 8'd0, 1, 8'h02, 0, 1, 0));
      tbl.push_back(v(1, 1, 8'h00, 2'b01, 1, 0, 8'd0, 4, 8'h04, 0, 1, 0));
      tbl.push_back(v(1, 1, 8'h00, 2'b01, 1, 0, 8'd0, 4, 8'h08, 0, 0, 1));
      tbl.push_back(v(1, 1, 8'h00, 2'b01, 1, 0, 8'd0, 1, 8'h08, 0, 0, 0));
      // rotate right, 2 steps from 0x01
      tbl.push_back(v(1, 0, 8'h01, 2'b10, 1, 0, 8'd0, 1, 8'h01, 0, 0, 0));
      tbl.push_back(v(1, 1, 8'h00, 2'b10, 1, 1, 8'd2, 1, 8'h01, 0, 1, 0));
      tbl.push_back(v(1, 1, 8'h00, 2'b10, 1, 0, 8'd0, 4, 8'h80, 1, 1, 0));
      tbl.push_back(v(1, 1, 8'h00, 2'b10, 1, 0, 8'd0, 4, 8'h40, 1, 0, 1));
      tbl.push_back(v(1, 1, 8'h00, 2'b10, 1, 0, 8'd0, 1, 8'h40, 1, 0, 0));
      // bounce, 9 steps from 0x40 with dir cleared
      tbl.push_back(v(0, 1, 8'h00, 2'b11, 1, 0, 8'd0, 1, 8'h01, 0, 0, 0));
      tbl.push_back(v(1, 0, 8'h40, 2'b11, 1, 0, 8'd0, 1, 8'h40, 0, 0, 0));
      tbl.push_back(v(1, 1, 8'h00, 2'b11, 1, 1, 8'd9, 1, 8'h40, 0, 1, 0));
      for (int i = 0; i < 9; i++)
         tbl.push_back(v(1, 1, 8'h00, 2'b11, 1, 0, 8'd0, 4, bdat[i], bdir[i],
                         (i != 8), (i == 8)));
      tbl.push_back(v(1, 1, 8'h00, 2'b11, 1, 0, 8'd0, 1, 8'h02, 0, 0, 0));

      drive(1, 1, 8'h00, 2'b00, 0, 0, 8'd0);
      #2;
      chk4("reset_held", 8'h00, 0, 0, 0);
      chk("reset_held.tick", 32'(bus.SC_RegPOINTTYPE_tick_Out), 32'd0);
      #10 rst = 1'b0;
      cyc(1);
      chk4("reset_rel", 8'h00, 0, 0, 0);

      foreach (tbl[k]) begin
         drive(tbl[k].clr_n, tbl[k].ld_n, tbl[k].din, tbl[k].mode,
               tbl[k].en, tbl[k].start, tbl[k].steps);
         cyc(tbl[k].ncyc);
         chk4($sformatf("vec%0d", k), tbl[k].e_data, tbl[k].e_dir,
              tbl[k].e_busy, tbl[k].e_done);
      end
`ifdef SC_REGPOINT_EDGEFLAG_EN
      chk("edge_pulses", 32'(edges), 32'd2);
`endif

      // free run with enable toggling: steps at E7 and E15
      drive(0, 1, 8'h00, 2'b01, 0, 0, 8'd0); cyc(1);
      drive(1, 1, 8'h00, 2'b01, 0, 1, 8'd0); cyc(1);
      chk4("free_start", 8'h01, 0, 1, 0);
      for (int c = 1; c <= 16; c++) begin
         drive(1, 1, 8'h00, 2'b01, (c % 2 == 1), 0, 8'd0);
         #1;
         if (c == 5) chk("free_tick_lo", 32'(bus.SC_RegPOINTTYPE_tick_Out), 32'd0);
         if (c == 7) chk("free_tick_hi", 32'(bus.SC_RegPOINTTYPE_tick_Out), 32'd1);
         cyc(1);
         if (c == 6)  chk("free_e6",  32'(bus.SC_RegPOINTTYPE_data_OutBUS), 32'h01);
         if (c == 7)  chk("free_e7",  32'(bus.SC_RegPOINTTYPE_data_OutBUS), 32'h02);
         if (c == 14) chk("free_e14", 32'(bus.SC_RegPOINTTYPE_data_OutBUS), 32'h02);
         if (c == 15) chk("free_e15", 32'(bus.SC_RegPOINTTYPE_data_OutBUS), 32'h04);
      end
      chk("free_busy", 32'(bus.SC_RegPOINTTYPE_busy_Out), 32'd1);
      drive(0, 1, 8'h00, 2'b01, 1, 1, 8'd0); cyc(1);
      chk4("free_clear", 8'h01, 0, 0, 0);
      drive(1, 1, 8'h00, 2'b01, 1, 0, 8'd0); cyc(1);
      chk4("free_after", 8'h01, 0, 0, 0);

      // load coincident with the first tick of a 2-step run
      drive(1, 1, 8'h00, 2'b01, 1, 1, 8'd2); cyc(1);
      drive(1, 1, 8'h00, 2'b01, 1, 0, 8'd0); cyc(3);
      chk4("ld_pre", 8'h01, 0, 1, 0);
      drive(1, 0, 8'hA5, 2'b01, 1, 0, 8'd0); cyc(1);
      chk4("ld_tick", 8'hA5, 0, 1, 0);
      drive(1, 1, 8'h00, 2'b01, 1, 0, 8'd0); cyc(4);
      chk4("ld_last", 8'h4B, 0, 0, 1);
      cyc(1);
      chk4("ld_idle", 8'h4B, 0, 0, 0);

      // async reset mid-run
      drive(1, 1, 8'h00, 2'b10, 1, 1, 8'd5); cyc(1);
      drive(1, 1, 8'h00, 2'b10, 1, 0, 8'd0); cyc(6);
      chk4("rst_pre", 8'hA5, 1, 1, 0);
      #2 rst = 1'b1;
      #1;
      chk4("rst_async", 8'h00, 0, 0, 0);
      chk("rst_async.tick", 32'(bus.SC_RegPOINTTYPE_tick_Out), 32'd0);
      #3 rst = 1'b0;
      cyc(2);
      chk4("rst_after", 8'h00, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
